// File: rtl/scr1_imem_rom_pkg.sv
// Shared types for the imem ROM bridge: memory-interface enums, bridge FSM states, counter width.
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif

package scr1_imem_rom_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR,
    HIT
  } type_scr1_imem_rom_fsm_e;

  localparam int unsigned SCR1_IMEM_ROM_CNT_W = 4;

endpackage

// File: rtl/scr1_imem_rom_lbuf.sv
// One-entry last-word buffer for the imem ROM bridge; the ROM is read-only, so only reset invalidates it.
module scr1_imem_rom_lbuf #(
  parameter int unsigned AWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_en,
  input  logic [AWIDTH-1:0] fill_addr,
  input  logic [31:0]       fill_data,
  input  logic [AWIDTH-1:0] lookup_addr,
  output logic              hit,
  output logic [31:0]       rdata
);

  logic              valid_q, valid_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d = 1'b1;
      addr_d  = fill_addr;
      data_d  = fill_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign hit   = valid_q && (addr_q == lookup_addr);
  assign rdata = data_q;

endmodule

// File: rtl/scr1_imem_rom_bridge.sv
// imem req/ack/resp to fixed-latency synchronous ROM adapter, one transaction outstanding.
// Optional last-word buffer enabled by SCR1_IMEM_ROM_LINEBUF_EN.
module scr1_imem_rom_bridge
  import scr1_imem_rom_pkg::*;
#(
  parameter int unsigned ROM_AWIDTH  = 12,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_req_ack,
  input  logic                         imem_req,
  input  type_scr1_mem_cmd_e           imem_cmd,
  input  logic [`SCR1_IMEM_AWIDTH-1:0] imem_addr,
  output logic [`SCR1_IMEM_DWIDTH-1:0] imem_rdata,
  output type_scr1_mem_resp_e          imem_resp,
  output logic                         mem_ce,
  output logic [ROM_AWIDTH-1:0]        mem_addr,
  input  logic [31:0]                  mem_rdata
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_lat_chk
    $error("scr1_imem_rom_bridge: MEM_LATENCY must be in 1..15");
  end

  type_scr1_imem_rom_fsm_e        fsm_q, fsm_d;
  logic [SCR1_IMEM_ROM_CNT_W-1:0] cnt_q, cnt_d;
  logic                           mem_ce_q, mem_ce_d;
  logic [ROM_AWIDTH-1:0]          mem_addr_q, mem_addr_d;

  logic                  busy_done;
  logic                  resp_cycle;
  logic                  accept;
  logic                  err;
  logic                  lb_hit;
  logic [31:0]           lb_rdata;
  logic [ROM_AWIDTH-1:0] word_addr;
  logic                  unused_addr_hi;

  assign word_addr      = imem_addr[ROM_AWIDTH+1:2];
  assign unused_addr_hi = ^imem_addr[`SCR1_IMEM_AWIDTH-1:ROM_AWIDTH+2];
  assign busy_done      = (fsm_q == BUSY) && (cnt_q == '0);

`ifdef SCR1_IMEM_ROM_LINEBUF_EN
  assign resp_cycle = busy_done || (fsm_q == HIT);

  scr1_imem_rom_lbuf #(
    .AWIDTH (ROM_AWIDTH)
  ) u_lbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .fill_en     (busy_done),
    .fill_addr   (mem_addr_q),
    .fill_data   (mem_rdata),
    .lookup_addr (word_addr),
    .hit         (lb_hit),
    .rdata       (lb_rdata)
  );
`else
  assign resp_cycle = busy_done;
  assign lb_hit     = 1'b0;
  assign lb_rdata   = '0;
`endif

  // Ack is gated by rst_n so nothing is accepted while reset is held.
  assign imem_req_ack = rst_n && ((fsm_q == IDLE) || resp_cycle);
  assign accept       = imem_req && imem_req_ack;
  assign err          = (imem_cmd != SCR1_MEM_CMD_RD) || (imem_addr[1:0] != 2'b00);

  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    mem_ce_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    if ((fsm_q == BUSY) && (cnt_q != '0)) begin
      cnt_d = cnt_q - SCR1_IMEM_ROM_CNT_W'(1);
    end else if (fsm_q == ERR) begin
      fsm_d = IDLE;
    end else if (accept) begin
      if (err) begin
        fsm_d = ERR;
      end else if (lb_hit) begin
        fsm_d = HIT;
      end else begin
        fsm_d      = BUSY;
        cnt_d      = SCR1_IMEM_ROM_CNT_W'(MEM_LATENCY);
        mem_ce_d   = 1'b1;
        mem_addr_d = word_addr;
      end
    end else if (resp_cycle) begin
      fsm_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      cnt_q      <= '0;
      mem_ce_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      mem_ce_q   <= mem_ce_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    imem_resp  = SCR1_MEM_RESP_NOTRDY;
    imem_rdata = '0;
    if (fsm_q == ERR) begin
      imem_resp = SCR1_MEM_RESP_RDY_ER;
    end else if (busy_done) begin
      imem_resp  = SCR1_MEM_RESP_RDY_OK;
      imem_rdata = mem_rdata;
    end else if (fsm_q == HIT) begin
      imem_resp  = SCR1_MEM_RESP_RDY_OK;
      imem_rdata = lb_rdata;
    end
  end

  assign mem_ce   = mem_ce_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_scr1_imem_rom_bridge.sv
// Directed bench for scr1_imem_rom_bridge: three instances at MEM_LATENCY 2, 1 and 15 with a ROM model each.
module tb_scr1_imem_rom_bridge;
  import scr1_imem_rom_pkg::*;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               req   = 1'b0;
  int                 sel   = 0;
  type_scr1_mem_cmd_e cmd   = SCR1_MEM_CMD_RD;
  logic [31:0]        addr  = '0;

  logic                ack_w    [3];
  type_scr1_mem_resp_e resp_w   [3];
  logic [31:0]         rdata_w  [3];
  logic                ce_w     [3];
  logic [11:0]         maddr_w  [3];
  logic [31:0]         mrdata_w [3];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [11:0] w);
    return {20'hC0DE0, w};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    logic [15:0] pv = '0;
    logic [11:0] pa [16];
    logic        req_g;

    assign req_g = req && (sel == g);

    always @(posedge clk) begin
      pv    <= {pv[14:0], ce_w[g]};
      pa[0] <= maddr_w[g];
      for (int k = 1; k < 16; k++) pa[k] <= pa[k-1];
    end

    assign mrdata_w[g] = pv[L-1] ? rom_word(pa[L-1]) : 32'hDEAD_BEEF;

    scr1_imem_rom_bridge #(
      .ROM_AWIDTH  (12),
      .MEM_LATENCY (L)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req_ack (ack_w[g]),
      .imem_req     (req_g),
      .imem_cmd     (cmd),
      .imem_addr    (addr),
      .imem_rdata   (rdata_w[g]),
      .imem_resp    (resp_w[g]),
      .mem_ce       (ce_w[g]),
      .mem_addr     (maddr_w[g]),
      .mem_rdata    (mrdata_w[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One request from idle; k counts cycles after the accept cycle.
  task automatic single(input int d, input logic [31:0] a, input type_scr1_mem_cmd_e c,
                        input int exp_k, input logic exp_ce,
                        input type_scr1_mem_resp_e exp_resp, input logic [31:0] exp_data);
    int          k;
    int          ce_k;
    logic [11:0] ce_a;
    logic [11:0] wa;
    wa = a[13:2];
    @(negedge clk);
    sel = d; req = 1'b1; addr = a; cmd = c;
    #1 chk("acc_ack", 32'(ack_w[d]), 32'd1);
    @(negedge clk);
    req = 1'b0; cmd = SCR1_MEM_CMD_WR; addr = 32'hFFFF_FFFF;
    k = 1; ce_k = -1; ce_a = '0;
    while (resp_w[d] == SCR1_MEM_RESP_NOTRDY && k < 40) begin
      if (ce_w[d]) begin ce_k = k; ce_a = maddr_w[d]; end
      if (k == 1) chk("idle_rdata", rdata_w[d], 32'd0);
      @(negedge clk);
      k++;
    end
    if (ce_w[d]) begin ce_k = k; ce_a = maddr_w[d]; end
    chk("resp_cycle", 32'(k), 32'(exp_k));
    chk("resp", 32'(resp_w[d]), 32'(exp_resp));
    chk("rdata", rdata_w[d], exp_data);
    chk("resp_ack", 32'(ack_w[d]), (exp_resp == SCR1_MEM_RESP_RDY_OK) ? 32'd1 : 32'd0);
    if (exp_ce) begin
      chk("ce_cycle", 32'(ce_k), 32'd1);
      chk("ce_addr", 32'(ce_a), 32'(wa));
    end else begin
      chk("no_ce", 32'(ce_k), 32'hFFFF_FFFF);
    end
    @(negedge clk);
    chk("resp_1cyc", 32'(resp_w[d]), 32'(SCR1_MEM_RESP_NOTRDY));
    cmd = SCR1_MEM_CMD_RD;
  endtask

  initial begin
    int   acks[$];
    int   ces[$];
    int   rsps[$];
    logic [31:0] dat[$];
    int   n;
    logic adv;
    logic seen;
    logic [31:0] ra;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_ack", 32'(ack_w[d]), 32'd0);
      chk("rst_resp", 32'(resp_w[d]), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("rst_ce", 32'(ce_w[d]), 32'd0);
    end
    chk("rst_maddr", 32'(maddr_w[0]), 32'd0);
    chk("rst_rdata", rdata_w[0], 32'd0);
    rst_n = 1'b1;

    single(0, 32'h0000_0010, SCR1_MEM_CMD_RD, 3, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'hC0DE_0004);

    // Back-to-back with req held; addr advances the cycle after each accept.
    @(negedge clk);
    sel = 0; req = 1'b1; cmd = SCR1_MEM_CMD_RD; addr = 32'h0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      adv = 1'b0;
      if (req && ack_w[0]) begin acks.push_back(c); adv = 1'b1; end
      if (ce_w[0]) ces.push_back(c);
      if (resp_w[0] == SCR1_MEM_RESP_RDY_OK) begin rsps.push_back(c); dat.push_back(rdata_w[0]); end
      @(negedge clk);
      if (adv) begin
        n++;
        if (n < 3) addr = 32'(n * 4);
        else req = 1'b0;
      end
    end
    chk("b2b_nack", 32'(acks.size()), 32'd3);
    chk("b2b_nce", 32'(ces.size()), 32'd3);
    chk("b2b_nresp", 32'(rsps.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_ack_cyc", (i < acks.size()) ? 32'(acks[i]) : 32'hFFFF_FFFF, 32'(3 * i));
      chk("b2b_ce_cyc", (i < ces.size()) ? 32'(ces[i]) : 32'hFFFF_FFFF, 32'(3 * i + 1));
      chk("b2b_resp_cyc", (i < rsps.size()) ? 32'(rsps[i]) : 32'hFFFF_FFFF, 32'(3 * i + 3));
      chk("b2b_data", (i < dat.size()) ? dat[i] : 32'hFFFF_FFFF, 32'hC0DE_0000 + 32'(i));
    end

    single(0, 32'h0000_0006, SCR1_MEM_CMD_RD, 1, 1'b0, SCR1_MEM_RESP_RDY_ER, 32'd0);
    single(0, 32'h0000_0008, SCR1_MEM_CMD_WR, 1, 1'b0, SCR1_MEM_RESP_RDY_ER, 32'd0);

    // Reset two cycles after accepting a read: the access is dropped silently.
    @(negedge clk);
    sel = 0; req = 1'b1; cmd = SCR1_MEM_CMD_RD; addr = 32'h0000_0010;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ce", 32'(ce_w[0]), 32'd0);
    chk("mid_rst_maddr", 32'(maddr_w[0]), 32'd0);
    chk("mid_rst_resp", 32'(resp_w[0]), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("mid_rst_ack", 32'(ack_w[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (resp_w[0] != SCR1_MEM_RESP_NOTRDY) seen = 1'b1;
    end
    chk("rst_no_resp", 32'(seen), 32'd0);
    single(0, 32'h0000_0010, SCR1_MEM_CMD_RD, 3, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'hC0DE_0004);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom & 32'hFFFF_FFFC;
      single(1, ra, SCR1_MEM_CMD_RD, 2, 1'b1, SCR1_MEM_RESP_RDY_OK, rom_word(ra[13:2]));
    end
    for (int i = 0; i < 3; i++) begin
      ra = $urandom & 32'hFFFF_FFFC;
      single(2, ra, SCR1_MEM_CMD_RD, 16, 1'b1, SCR1_MEM_RESP_RDY_OK, rom_word(ra[13:2]));
    end

    single(0, 32'h0000_0020, SCR1_MEM_CMD_RD, 3, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'hC0DE_0008);
`ifdef SCR1_IMEM_ROM_LINEBUF_EN
    single(0, 32'h0000_0020, SCR1_MEM_CMD_RD, 1, 1'b0, SCR1_MEM_RESP_RDY_OK, 32'hC0DE_0008);
`else
    single(0, 32'h0000_0020, SCR1_MEM_CMD_RD, 3, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'hC0DE_0008);
`endif
    single(0, 32'h0000_0024, SCR1_MEM_CMD_RD, 3, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'hC0DE_0009);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
